// File: rtl/fir_pkg.sv
// Shared definitions for the folded symmetric FIR controller: state encoding,
// default geometry and the modular ring arithmetic used for buffer addressing.
package fir_pkg;

  localparam int TAPS_DEF     = 21;
  localparam int CENTER_DEF   = (TAPS_DEF - 1) / 2;
  localparam int PIPE_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLEAR,
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Operands are already reduced below m, so one conditional correction suffices
  // and the ring never relies on the 2**ADDR_W wrap of the address bus.
  function automatic int mod_add(input int a, input int b, input int m);
    int s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

  function automatic int mod_sub(input int a, input int b, input int m);
    return (a >= b) ? a - b : a + m - b;
  endfunction

endpackage

// File: rtl/fir_ring_addr.sv
// Circular sample-buffer pointers: write pointer, newest-sample latch and the
// symmetric read pair (newest-k, oldest+k) for the current fold step k.
module fir_ring_addr
  import fir_pkg::*;
#(
  parameter int TAPS   = TAPS_DEF,
  parameter int ADDR_W = 5,
  parameter int CIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_wclr,
  input  logic [CIDX_W-1:0] i_k,
  output logic [ADDR_W-1:0] o_wptr,
  output logic [ADDR_W-1:0] o_rd_a,
  output logic [ADDR_W-1:0] o_rd_b
);

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_newest;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_newest <= '0;
    end else if (i_wclr) begin
      r_wptr <= '0;
    end else if (i_push) begin
      r_newest <= r_wptr;
      r_wptr   <= ADDR_W'(mod_add(int'(r_wptr), 1, TAPS));
    end
  end

  // Oldest sample sits one slot after the newest, so oldest+k = newest+1+k.
  assign o_wptr = r_wptr;
  assign o_rd_a = ADDR_W'(mod_sub(int'(r_newest), int'(i_k), TAPS));
  assign o_rd_b = ADDR_W'(mod_add(int'(r_newest), int'(i_k) + 1, TAPS));

endmodule

// File: rtl/fir_fold_ctrl.sv
// Sequencer for a folded symmetric FIR: buffer clear, input handshake, one
// pre-add/MAC step per coefficient pair, pipeline drain and output strobe.
module fir_fold_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS     = TAPS_DEF,
  parameter int ADDR_W   = 5,
  parameter int CIDX_W   = 4,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr_req,
  output logic              wr_en,
  output logic              wr_zero,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [CIDX_W-1:0] coef_idx,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              center,
  output logic              out_valid,
  output logic              busy
);

  localparam int CENTER = (TAPS - 1) / 2;
  localparam int CNT_W  = $clog2((TAPS > PIPE_LAT) ? TAPS : PIPE_LAT);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_clr_pend;

  logic               w_clr_go;
  logic               w_accept;
  logic               w_clear_done;
  logic [CIDX_W-1:0]  w_k;
  logic [ADDR_W-1:0]  w_wptr;
  logic [ADDR_W-1:0]  w_rd_a;
  logic [ADDR_W-1:0]  w_rd_b;

  assign w_clr_go     = r_clr_pend | clr_req;
  assign w_accept     = (r_state == ST_IDLE) && !w_clr_go && in_valid;
  assign w_clear_done = (r_state == ST_CLEAR) && (r_cnt == CNT_W'(TAPS - 1));
  assign w_k          = CIDX_W'(r_cnt);

  fir_ring_addr #(
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W),
    .CIDX_W (CIDX_W)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_accept),
    .i_wclr (w_clear_done),
    .i_k    (w_k),
    .o_wptr (w_wptr),
    .o_rd_a (w_rd_a),
    .o_rd_b (w_rd_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
        end
        ST_CLEAR: begin
          if (w_clear_done) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_clr_pend <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_clr_go)      r_state <= ST_CLEAR;
          else if (in_valid) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (clr_req) r_clr_pend <= 1'b1;
          if (r_cnt == CNT_W'(CENTER)) begin
            r_state <= ST_DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (clr_req) r_clr_pend <= 1'b1;
          if (r_cnt == CNT_W'(PIPE_LAT - 1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch can be inferred.
  always_comb begin
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_zero   = 1'b0;
    wr_addr   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    coef_idx  = '0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    center    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_zero = 1'b1;
        wr_addr = ADDR_W'(r_cnt);
        busy    = 1'b1;
      end
      ST_IDLE: begin
        in_ready = !w_clr_go;
        wr_en    = w_accept;
        wr_addr  = w_accept ? w_wptr : '0;
      end
      ST_RUN: begin
        mac_en    = 1'b1;
        coef_idx  = w_k;
        rd_addr_a = w_rd_a;
        rd_addr_b = w_rd_b;
        mac_clr   = (r_cnt == '0);
        center    = (r_cnt == CNT_W'(CENTER));
        busy      = 1'b1;
      end
      ST_DRAIN: begin
        out_valid = (r_cnt == CNT_W'(PIPE_LAT - 1));
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// Directed bench for fir_fold_ctrl at default geometry (21 taps, PIPE_LAT 2):
// every checked cycle compares the full output bundle against a hand-built vector.
module tb_fir_fold_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr_req = 1'b0;
  logic       in_ready, wr_en, wr_zero, mac_en, mac_clr, center, out_valid, busy;
  logic [4:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [3:0] coef_idx;
  logic [26:0] obs;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_ov  = 0;

  always #5 clk = ~clk;

  fir_fold_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr_req   (clr_req),
    .wr_en     (wr_en),
    .wr_zero   (wr_zero),
    .wr_addr   (wr_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .coef_idx  (coef_idx),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .center    (center),
    .out_valid (out_valid),
    .busy      (busy)
  );

  assign obs = {in_ready, wr_en, wr_zero, wr_addr, rd_addr_a, rd_addr_b, coef_idx,
                mac_en, mac_clr, center, out_valid, busy};

  function automatic logic [26:0] pack(input logic ir, input logic we, input logic wz,
                                       input int wa, input int ra, input int rb, input int ci,
                                       input logic me, input logic mc, input logic ce,
                                       input logic ov, input logic bs);
    return {ir, we, wz, 5'(wa), 5'(ra), 5'(rb), 4'(ci), me, mc, ce, ov, bs};
  endfunction

  function automatic logic [26:0] exp_idle(input logic ir, input logic we, input int wa);
    return pack(ir, we, 1'b0, wa, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [26:0] exp_clear(input int a);
    return pack(1'b0, 1'b1, 1'b1, a, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [26:0] exp_run(input int n, input int k);
    return pack(1'b0, 1'b0, 1'b0, 0, (n + 21 - k) % 21, (n + 1 + k) % 21, k,
                1'b1, k == 0, k == 10, 1'b0, 1'b1);
  endfunction

  function automatic logic [26:0] exp_drain(input logic last);
    return pack(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, last, 1'b1);
  endfunction

  // 21 CLEAR cycles; in_valid may be held high to show it is ignored.
  task automatic clear_cycles(input string tag, input logic hold_valid);
    for (int c = 0; c < 21; c++) begin
      in_valid = hold_valid;
      @(negedge clk);
      n_vec++;
      if (obs !== exp_clear(c)) begin
        n_err++;
        $display("FAIL %s clear c=%0d got=%h want=%h", tag, c, obs, exp_clear(c));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Starts in IDLE just after a rising edge; checks handshake, 11 RUN steps, 2 DRAIN
  // cycles and returns just after the edge that re-enters IDLE (unless aborted).
  task automatic do_sample(input string tag, input int wp, input bit hold,
                           input int clr_k, input int abort_k);
    logic [26:0] e;
    in_valid = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      if (c >= 1 && !hold) in_valid = 1'b0;
      clr_req = (c - 1 == clr_k);
      if (c - 1 == abort_k) rst = 1'b0;
      if (c - 1 == abort_k) e = '0;
      else if (c == 0)      e = exp_idle(1'b1, 1'b1, wp);
      else if (c <= 11)     e = exp_run(wp, c - 1);
      else                  e = exp_drain(c == 13);
      @(negedge clk);
      if (wr_en && in_ready) n_acc++;
      if (out_valid) n_ov++;
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL %s wp=%0d c=%0d got=%h want=%h", tag, wp, c, obs, e);
      end
      if (c - 1 == abort_k) begin
        clr_req = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    clr_req = 1'b0;
  endtask

  task automatic check_init_clear(input string tag);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL %s init got=%h want=0", tag, obs);
    end
    @(posedge clk); #1;
    clear_cycles(tag, 1'b0);
    @(negedge clk);
    n_vec++;
    if (obs !== exp_idle(1'b1, 1'b0, 0)) begin
      n_err++;
      $display("FAIL %s ready got=%h want=%h", tag, obs, exp_idle(1'b1, 1'b0, 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== '0) begin
        n_err++;
        $display("FAIL reset_hold c=%0d got=%h want=0", c, obs);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_init_clear("reset");
  endtask

  task automatic test_first_sample();
    do_sample("first", 0, 1'b0, 99, 99);
    @(negedge clk);
    n_vec++;
    if (obs !== exp_idle(1'b1, 1'b0, 0)) begin
      n_err++;
      $display("FAIL first_ready got=%h want=%h", obs, exp_idle(1'b1, 1'b0, 0));
    end
    @(posedge clk); #1;
  endtask

  // Samples 2..22: wr_addr walks 1..20 and wraps to 0 for sample 22.
  task automatic test_back_to_back();
    for (int i = 1; i <= 21; i++) do_sample("b2b", i % 21, 1'b0, 99, 99);
  endtask

  task automatic test_hold_valid();
    int acc0, ov0;
    acc0 = n_acc;
    ov0  = n_ov;
    for (int i = 1; i <= 5; i++) do_sample("hold", i, 1'b1, 99, 99);
    in_valid = 1'b0;
    n_vec++;
    if (n_acc - acc0 !== 5) begin
      n_err++;
      $display("FAIL hold_accepts got=%0d want=5", n_acc - acc0);
    end
    n_vec++;
    if (n_ov - ov0 !== 5) begin
      n_err++;
      $display("FAIL hold_out_valid got=%0d want=5", n_ov - ov0);
    end
  endtask

  task automatic test_clr_in_run();
    do_sample("clr_run", 6, 1'b0, 4, 99);
    in_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs !== exp_idle(1'b0, 1'b0, 0)) begin
      n_err++;
      $display("FAIL clr_run_pend got=%h want=%h", obs, exp_idle(1'b0, 1'b0, 0));
    end
    @(posedge clk); #1;
    clear_cycles("clr_run", 1'b1);
    do_sample("clr_run_next", 0, 1'b0, 99, 99);
  endtask

  task automatic test_clr_in_idle();
    clr_req  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (obs !== exp_idle(1'b0, 1'b0, 0)) begin
      n_err++;
      $display("FAIL clr_idle_win got=%h want=%h", obs, exp_idle(1'b0, 1'b0, 0));
    end
    @(posedge clk); #1;
    clr_req = 1'b0;
    clear_cycles("clr_idle", 1'b0);
    do_sample("clr_idle_next", 0, 1'b0, 99, 99);
  endtask

  task automatic test_reset_mid_run();
    do_sample("abort", 1, 1'b0, 99, 6);
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL abort_held got=%h want=0", obs);
    end
    @(posedge clk); #1;
    check_init_clear("abort");
    do_sample("abort_next", 0, 1'b0, 99, 99);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_sample();
    test_back_to_back();
    test_hold_valid();
    test_clr_in_run();
    test_clr_in_idle();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_fold_ctrl.md
Name: fir_fold_ctrl

Overview:
Sequencer for a folded 21-tap symmetric FIR: one pre-adder, one multiplier and one accumulator replace the fully parallel symmetric pipeline.
- Owns the 21-entry circular sample buffer addressing, the coefficient index and the MAC clear/enable/center controls.
- Owns the input handshake and the output-valid strobe.
- Sits between the sample source and the folded datapath (buffer RAM, coefficient ROM, MAC). Carries no sample data itself.

Parameters:
TAPS, 21, filter length; must be odd, center tap index (TAPS-1)/2
ADDR_W, 5, buffer address width, 2**ADDR_W >= TAPS
CIDX_W, 4, coefficient index width, 2**CIDX_W >= (TAPS+1)/2
PIPE_LAT, 2, datapath cycles from last MAC issue to valid accumulator (>=1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  source has a sample on the datapath input
in_ready  out  1  controller accepts a sample this cycle
clr_req  in  1  single-cycle request to zero the sample buffer
wr_en  out  1  buffer write strobe
wr_zero  out  1  write zero instead of the input sample
wr_addr  out  ADDR_W  buffer write address
rd_addr_a  out  ADDR_W  pre-adder operand A address (newer sample)
rd_addr_b  out  ADDR_W  pre-adder operand B address (older sample)
coef_idx  out  CIDX_W  coefficient ROM index
mac_en  out  1  MAC issues this cycle
mac_clr  out  1  MAC loads the product instead of accumulating
center  out  1  pre-adder forces operand B to zero (center tap)
out_valid  out  1  one-cycle strobe, datapath filter_out valid
busy  out  1  high in every state except IDLE

Behaviour:
- States: INIT, CLEAR, IDLE, RUN, DRAIN.
- All outputs are decoded from registered state/counters.
- Reset asserted: state=INIT, cnt=0, wptr=0, clr_pend=0. All outputs are 0 immediately and asynchronously, including in reset mid-operation.
- INIT: lasts 1 cycle, all outputs 0, then goes to CLEAR.
- CLEAR: runs TAPS cycles, cnt 0..TAPS-1.
  - wr_en=1, wr_zero=1, wr_addr=cnt, in_ready=0.
  - Exit to IDLE with wptr=0 and clr_pend=0.
- IDLE: in_ready=1, busy=0.
  - If clr_pend or clr_req, go to CLEAR instead; in_ready=0 that cycle.
  - Otherwise, handshake when in_valid & in_ready:
    - wr_en=1 and wr_addr=wptr in the same cycle (combinational from in_valid);
    - latch newest=wptr;
    - wptr <= (wptr+1) mod TAPS, wrapping TAPS-1 -> 0;
    - go to RUN with k=0.
- RUN: lasts (TAPS+1)/2 cycles, k=0..(TAPS-1)/2.
  - mac_en=1, coef_idx=k.
  - rd_addr_a = (newest-k) mod TAPS.
  - rd_addr_b = (newest+1+k) mod TAPS, i.e. the oldest+k.
  - mac_clr=1 only at k=0.
  - center=1 only at k=(TAPS-1)/2.
  - Modular arithmetic must not use 2**ADDR_W wrap.
- DRAIN: PIPE_LAT cycles, mac_en=0. out_valid=1 in the final DRAIN cycle, then go to IDLE.
- Sample period at defaults: 1 (IDLE) + 11 + 2 = 14 cycles.
  - Handshake at cycle 0, RUN at cycles 1..11, out_valid at cycle 13, in_ready at cycle 14.
- clr_req outside IDLE sets clr_pend; the current sample still completes with out_valid. Multiple requests collapse to one.
- clr_req and in_valid together in IDLE: clear wins, and the sample is not accepted.
- in_ready is never high outside IDLE. No sample is ever dropped or double-written.
- rd addresses and coef_idx are 0 when mac_en=0. wr_addr is 0 when wr_en=0.

Decomposition:
- Shared package fir_pkg holds:
  - state encoding (INIT/CLEAR/IDLE/RUN/DRAIN);
  - TAPS, center index, PIPE_LAT defaults;
  - a mod-TAPS add/subtract function.
- One natural sub-module, fir_ring_addr: holds wptr/newest and produces the mod-TAPS write and pair read addresses from k.
- FSM and counters stay in fir_fold_ctrl.

Test Plan:
1. Release rst at t0 -> INIT 1 cycle; CLEAR 21 cycles with wr_en=1, wr_zero=1, wr_addr 0..20; in_ready rises on cycle 22.
2. First sample, wptr=0 -> wr_addr=0; RUN k=0 gives rd_a=0, rd_b=1, mac_clr=1; k=10 gives rd_a=11, rd_b=11, center=1, coef_idx=10; out_valid 13 cycles after the handshake; in_ready at cycle 14.
3. 22 samples back-to-back -> wr_addr 0..20 then 0; for sample 22 (newest=0), k=1 gives rd_a=20, rd_b=2.
4. in_valid held high for 5 samples -> exactly one accept every 14 cycles, 5 out_valid pulses, never two accepts within 14 cycles.
5. clr_req pulse at RUN k=4 -> out_valid still issued; IDLE is skipped into CLEAR for 21 cycles; next accepted sample writes wr_addr=0.
6. rst low at RUN k=6 -> all outputs 0 in the same cycle; after release, INIT then full CLEAR; no out_valid is issued for the aborted sample.
